// File: rtl/read_port_pkg.sv
// Shared constants, snapshot FSM state type and the element seed function
// for the read_port API test target.
package read_port_pkg;

  localparam int MAX_WIDTH = 512;

  localparam logic [127:0] BASE_PATTERN = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    ACK  = 2'd2
  } snap_state_e;

  // Seed for wide-array element idx: BASE with the lowest byte of each half
  // replaced by idx. Callers truncate the result to their WIDTH.
  function automatic logic [MAX_WIDTH-1:0] idx_bytes(input int width, input logic [7:0] idx);
    logic [MAX_WIDTH-1:0] v;
    int half;
    half = width / 2;
    v    = MAX_WIDTH'(BASE_PATTERN);
    for (int b = 0; b < MAX_WIDTH; b++) begin
      if (b >= width) begin
        v[b] = 1'b0;
      end else if (b < 8) begin
        v[b] = idx[b];
      end else if ((b >= half) && (b < half + 8)) begin
        v[b] = idx[b - half];
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/read_port_snap_fsm.sv
// Snapshot handshake: IDLE -> CAPT -> ACK -> IDLE, capturing the wide word
// and cycle count during CAPT and holding them until the next capture.
module read_port_snap_fsm
  import read_port_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             snap_req,
  input  logic [WIDTH-1:0] cur_wide,
  input  logic [31:0]      cur_count,
  output logic             snap_busy,
  output logic             snap_ack,
  output logic [WIDTH-1:0] snap_wide,
  output logic [31:0]      snap_count
);

  snap_state_e state_q;
  snap_state_e state_d;

  // NOTE: state is updated with non-blocking assignments so every flop in the
  // design samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    snap_busy = 1'b0;
    snap_ack  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (snap_req) state_d = CAPT;
      end
      CAPT: begin
        snap_busy = 1'b1;
        state_d   = ACK;
      end
      ACK: begin
        snap_busy = 1'b1;
        snap_ack  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture happens at the edge leaving CAPT, so the values are those visible
  // during the CAPT cycle and appear on the outputs together with snap_ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_wide  <= '0;
      snap_count <= '0;
    end else if (state_q == CAPT) begin
      snap_wide  <= cur_wide;
      snap_count <= cur_count;
    end
  end

endmodule

// File: rtl/read_port_gen.sv
// Read-port target: scalar, wide, 1-bit-array and wide-array outputs that
// evolve per enabled cycle, a writable wide array and a snapshot handshake.
module read_port_gen
  import read_port_pkg::*;
#(
  parameter int WIDTH   = 128,
  parameter int DEPTH   = 128,
  parameter int DYNAMIC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_en,
  input  logic [7:0]       wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             snap_req,
  output logic             read_port,
  output logic [WIDTH-1:0] read_wide_port,
  output logic             read_array_port      [0:DEPTH-1],
  output logic [WIDTH-1:0] read_wide_array_port [0:DEPTH-1],
  output logic [31:0]      cycle_count,
  output logic             wr_err,
  output logic             snap_busy,
  output logic             snap_ack,
  output logic [WIDTH-1:0] snap_wide,
  output logic [31:0]      snap_count
);

  localparam logic [WIDTH-1:0] BASE_W = WIDTH'(BASE_PATTERN);
  localparam logic             DYN    = (DYNAMIC != 0);

  logic        adv;
  logic        wr_in_range;
  logic [31:0] count_q;

  assign adv         = DYN & en;
  assign wr_in_range = (int'({24'd0, wr_idx}) < DEPTH);
  assign cycle_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_port      <= 1'b1;
      read_wide_port <= BASE_W;
      count_q        <= '0;
    end else if (adv) begin
      read_port      <= ~read_port;
      read_wide_port <= {read_wide_port[WIDTH-2:0], read_wide_port[WIDTH-1]};
      count_q        <= count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        read_array_port[i] <= 1'(i % 2);
      end
    end else if (adv) begin
      for (int i = 0; i < DEPTH; i++) begin
        read_array_port[i] <= read_array_port[(i + 1) % DEPTH];
      end
    end
  end

  // NOTE: the wide array is built from flops rather than RAM because every
  // element needs its own asynchronous seed value and a per-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        read_wide_array_port[i] <= WIDTH'(idx_bytes(WIDTH, 8'(i)));
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && wr_in_range && (wr_idx == 8'(i))) begin
          read_wide_array_port[i] <= wr_data;
        end else if (adv) begin
          read_wide_array_port[i] <= read_wide_array_port[i] + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else if (wr_en && !wr_in_range) begin
      wr_err <= 1'b1;
    end
  end

  read_port_snap_fsm #(
    .WIDTH(WIDTH)
  ) u_snap (
    .clk       (clk),
    .rst_n     (rst_n),
    .snap_req  (snap_req),
    .cur_wide  (read_wide_port),
    .cur_count (count_q),
    .snap_busy (snap_busy),
    .snap_ack  (snap_ack),
    .snap_wide (snap_wide),
    .snap_count(snap_count)
  );

endmodule

// File: tb/tb_read_port_gen.sv
// Directed self-checking bench for read_port_gen at WIDTH=128, DEPTH=128, DYNAMIC=1.
module tb_read_port_gen;

  localparam int WIDTH = 128;
  localparam int DEPTH = 128;

  localparam logic [127:0] BASE     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] SEED0    = 128'h0123_4567_89AB_CD00_FEDC_BA98_7654_3200;
  localparam logic [127:0] SEED10   = 128'h0123_4567_89AB_CD0A_FEDC_BA98_7654_320A;
  localparam logic [127:0] SEED127  = 128'h0123_4567_89AB_CD7F_FEDC_BA98_7654_327F;
  localparam logic [127:0] E127_P3  = 128'h0123_4567_89AB_CD7F_FEDC_BA98_7654_3282;
  localparam logic [127:0] E11_P4   = 128'h0123_4567_89AB_CD0B_FEDC_BA98_7654_320F;
  localparam logic [127:0] E72_P4   = 128'h0123_4567_89AB_CD48_FEDC_BA98_7654_324C;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             wr_en;
  logic [7:0]       wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             snap_req;
  logic             read_port;
  logic [WIDTH-1:0] read_wide_port;
  logic             read_array_port      [0:DEPTH-1];
  logic [WIDTH-1:0] read_wide_array_port [0:DEPTH-1];
  logic [31:0]      cycle_count;
  logic             wr_err;
  logic             snap_busy;
  logic             snap_ack;
  logic [WIDTH-1:0] snap_wide;
  logic [31:0]      snap_count;

  int checks   = 0;
  int failures = 0;
  int rot      = 0;

  read_port_gen #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .DYNAMIC(1)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .en                  (en),
    .wr_en               (wr_en),
    .wr_idx              (wr_idx),
    .wr_data             (wr_data),
    .snap_req            (snap_req),
    .read_port           (read_port),
    .read_wide_port      (read_wide_port),
    .read_array_port     (read_array_port),
    .read_wide_array_port(read_wide_array_port),
    .cycle_count         (cycle_count),
    .wr_err              (wr_err),
    .snap_busy           (snap_busy),
    .snap_ack            (snap_ack),
    .snap_wide           (snap_wide),
    .snap_count          (snap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rotl(input logic [127:0] v, input int n);
    logic [127:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[126:0], r[127]};
    return r;
  endfunction

  // Advance to just after the next rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; snap_req = 1'b0;
    #23;
    checks++; if (read_port !== 1'b1) begin failures++; $display("FAIL reset_read_port got=%b exp=1", read_port); end
    checks++; if (read_wide_port !== BASE) begin failures++; $display("FAIL reset_wide got=%h exp=%h", read_wide_port, BASE); end
    checks++; if (read_array_port[5] !== 1'b1) begin failures++; $display("FAIL reset_arr5 got=%b exp=1", read_array_port[5]); end
    checks++; if (read_array_port[4] !== 1'b0) begin failures++; $display("FAIL reset_arr4 got=%b exp=0", read_array_port[4]); end
    checks++; if (read_wide_array_port[0] !== SEED0) begin failures++; $display("FAIL reset_elem0 got=%h exp=%h", read_wide_array_port[0], SEED0); end
    checks++; if (read_wide_array_port[127] !== SEED127) begin failures++; $display("FAIL reset_elem127 got=%h exp=%h", read_wide_array_port[127], SEED127); end
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", cycle_count); end
    checks++; if ({wr_err, snap_busy, snap_ack} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {wr_err, snap_busy, snap_ack}); end
    checks++; if (snap_count !== 32'd0) begin failures++; $display("FAIL reset_snap_count got=%h exp=0", snap_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_advance();
    en = 1'b1;
    repeat (3) begin tick(); rot++; end
    en = 1'b0;
    checks++; if (cycle_count !== 32'd3) begin failures++; $display("FAIL adv_count got=%0d exp=3", cycle_count); end
    checks++; if (read_port !== 1'b0) begin failures++; $display("FAIL adv_read_port got=%b exp=0", read_port); end
    checks++; if (read_wide_port !== rotl(BASE, 3)) begin failures++; $display("FAIL adv_wide got=%h exp=%h", read_wide_port, rotl(BASE, 3)); end
    checks++; if (read_array_port[0] !== 1'b1) begin failures++; $display("FAIL adv_arr0 got=%b exp=1", read_array_port[0]); end
    checks++; if (read_array_port[1] !== 1'b0) begin failures++; $display("FAIL adv_arr1 got=%b exp=0", read_array_port[1]); end
    checks++; if (read_wide_array_port[0] !== SEED0 + 128'd3) begin failures++; $display("FAIL adv_elem0 got=%h exp=%h", read_wide_array_port[0], SEED0 + 128'd3); end
    checks++; if (read_wide_array_port[127] !== E127_P3) begin failures++; $display("FAIL adv_elem127 got=%h exp=%h", read_wide_array_port[127], E127_P3); end
    tick();
    checks++; if (cycle_count !== 32'd3) begin failures++; $display("FAIL adv_hold_count got=%0d exp=3", cycle_count); end
  endtask

  task automatic test_write();
    en = 1'b1; wr_en = 1'b1; wr_idx = 8'd10; wr_data = 128'hDEAD;
    tick(); rot++;
    en = 1'b0; wr_en = 1'b0;
    checks++; if (read_wide_array_port[10] !== 128'hDEAD) begin failures++; $display("FAIL wr_elem10 got=%h exp=dead", read_wide_array_port[10]); end
    checks++; if (read_wide_array_port[11] !== E11_P4) begin failures++; $display("FAIL wr_elem11 got=%h exp=%h", read_wide_array_port[11], E11_P4); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL wr_err_early got=%b exp=0", wr_err); end
    wr_en = 1'b1; wr_idx = 8'd200; wr_data = 128'h1234;
    tick();
    wr_en = 1'b0;
    checks++; if (wr_err !== 1'b1) begin failures++; $display("FAIL wr_err_set got=%b exp=1", wr_err); end
    checks++; if (read_wide_array_port[72] !== E72_P4) begin failures++; $display("FAIL wr_oob_elem72 got=%h exp=%h", read_wide_array_port[72], E72_P4); end
    checks++; if (read_wide_array_port[10] !== 128'hDEAD) begin failures++; $display("FAIL wr_oob_elem10 got=%h exp=dead", read_wide_array_port[10]); end
    tick();
    checks++; if (wr_err !== 1'b1) begin failures++; $display("FAIL wr_err_sticky got=%b exp=1", wr_err); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.count_q;
    en = 1'b1;
    tick(); rot++;
    checks++; if (cycle_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_max got=%h exp=ffffffff", cycle_count); end
    tick(); rot++;
    en = 1'b0;
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL wrap_zero got=%h exp=0", cycle_count); end
    checks++; if (snap_ack !== 1'b0) begin failures++; $display("FAIL wrap_no_flag got=%b exp=0", snap_ack); end
  endtask

  task automatic test_snapshot();
    int acks;
    int guard;
    en    = 1'b1;
    guard = 0;
    while ((cycle_count !== 32'd7) && (guard < 20)) begin
      tick(); rot++; guard++;
    end
    checks++; if (cycle_count !== 32'd7) begin failures++; $display("FAIL snap_reach7 got=%0d exp=7", cycle_count); end
    snap_req = 1'b1;
    tick(); rot++;
    checks++; if ({snap_busy, snap_ack} !== 2'b10) begin failures++; $display("FAIL snap_capt got=%b exp=10", {snap_busy, snap_ack}); end
    tick(); rot++;
    snap_req = 1'b0;
    checks++; if ({snap_busy, snap_ack} !== 2'b11) begin failures++; $display("FAIL snap_ack got=%b exp=11", {snap_busy, snap_ack}); end
    checks++; if (snap_count !== 32'd8) begin failures++; $display("FAIL snap_count got=%0d exp=8", snap_count); end
    checks++; if (snap_wide !== rotl(BASE, rot - 1)) begin failures++; $display("FAIL snap_wide got=%h exp=%h", snap_wide, rotl(BASE, rot - 1)); end
    acks = 0;
    repeat (4) begin
      tick(); rot++;
      if (snap_ack === 1'b1) acks++;
    end
    en = 1'b0;
    checks++; if (acks !== 0) begin failures++; $display("FAIL snap_extra_ack got=%0d exp=0", acks); end
    checks++; if (snap_busy !== 1'b0) begin failures++; $display("FAIL snap_idle got=%b exp=0", snap_busy); end
    checks++; if (snap_count !== 32'd8) begin failures++; $display("FAIL snap_held got=%0d exp=8", snap_count); end
  endtask

  task automatic test_reset_in_capt();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    checks++; if (snap_busy !== 1'b1) begin failures++; $display("FAIL rst_capt_busy got=%b exp=1", snap_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({snap_busy, snap_ack} !== 2'b00) begin failures++; $display("FAIL rst_snap got=%b exp=00", {snap_busy, snap_ack}); end
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", cycle_count); end
    checks++; if (read_wide_port !== BASE) begin failures++; $display("FAIL rst_wide got=%h exp=%h", read_wide_port, BASE); end
    checks++; if (read_port !== 1'b1) begin failures++; $display("FAIL rst_read_port got=%b exp=1", read_port); end
    checks++; if (read_wide_array_port[10] !== SEED10) begin failures++; $display("FAIL rst_elem10 got=%h exp=%h", read_wide_array_port[10], SEED10); end
    checks++; if (read_array_port[5] !== 1'b1) begin failures++; $display("FAIL rst_arr5 got=%b exp=1", read_array_port[5]); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL rst_wr_err got=%b exp=0", wr_err); end
    checks++; if ({snap_count, snap_wide} !== '0) begin failures++; $display("FAIL rst_snap_regs got=%h/%h exp=0", snap_count, snap_wide); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_advance();
    test_write();
    test_wrap();
    test_snapshot();
    test_reset_in_capt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
